// File: rtl/strobe_uart_tx.sv
// -----------------------------------------------------------------------------
// strobe_uart_tx
//
// UART transmitter fed by single-cycle strobes from the strobe clock-crossing
// stage of the usb2serial path. Everything runs on posedge clk in the UART
// domain. Each strobe captures one byte into a small FIFO. A frame FSM pops
// bytes and serialises them LSB-first (8N1 by default).
//
// Configuration macro:
//   STROBE_UART_PARITY_EN  - when defined, a PARITY state is inserted after
//                            data bit 7 and drives even parity (^byte), so the
//                            frame is 8E1. When undefined, there is no parity
//                            state or logic and the frame is 8N1.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   DEPTH_LOG2    FIFO depth is 2**DEPTH_LOG2 bytes (1..8)
//
// Ports:
//   clk           UART-domain clock
//   reset         synchronous, active-high reset
//   strobe_in     1-cycle capture pulse from the crossing stage
//   data_in       byte, valid on the strobe cycle
//   overflow_clr  clears the sticky overflow flag
//   tx            UART serial line, idle high
//   busy          high while a frame is on the line
//   fifo_count    bytes queued, not counting the byte being shifted
//   fifo_full     fifo_count == 2**DEPTH_LOG2
//   overflow      sticky; set when a strobe found no room
// -----------------------------------------------------------------------------
module strobe_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  strobe_in,
  input  logic [7:0]            data_in,
  input  logic                  overflow_clr,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  overflow
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;       // pointer width
  localparam int CW    = DEPTH_LOG2 + 1;   // count width (full != empty)

  localparam logic [15:0] TIMER_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Frame FSM state encoding
  // ---------------------------------------------------------------------------
`ifdef STROBE_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;

  // Even parity over a data byte: the parity bit makes the total count of
  // ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,   full_d;
  logic          ovf_q,    ovf_d;

  state_e        state_q;
  logic [15:0]   timer_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          busy_q;
`ifdef STROBE_UART_PARITY_EN
  logic          par_q;
`endif

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          timer_zero_s;
  logic [7:0]    rd_data_s;

  assign timer_zero_s = (timer_q == 16'd0);
  assign rd_data_s    = mem_q[rd_ptr_q];

  // Pop/push decisions. A frame is started (and a byte popped) either from
  // IDLE or at the very end of a stop bit, which is what gives back-to-back
  // frames without an idle gap. A push into a full FIFO is still legal when a
  // pop happens in the same cycle.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (count_q != CNT_ZERO) begin
      if (state_q == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_q == STOP) && timer_zero_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    if (strobe_in) begin
      push_s = (!full_q) || pop_s;
      drop_s = !push_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Next-state for FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;          // none, or push+pop together
    endcase

    full_d = (count_d == CNT_DEPTH);

    // A dropped strobe wins over a clear arriving in the same cycle.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO data array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Frame FSM with registered line and busy outputs. The bit timer counts
  // down from CLKS_PER_BIT-1 and every bit boundary is its zero cycle.
  // In DATA, sh_q[0] always holds the bit currently on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef STROBE_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            state_q <= START;
            sh_q    <= rd_data_s;
`ifdef STROBE_UART_PARITY_EN
            par_q   <= even_parity(rd_data_s);
`endif
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            timer_q <= TIMER_RELOAD;
          end else begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        START: begin
          if (timer_zero_s) begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
            idx_q   <= 3'd0;
            timer_q <= TIMER_RELOAD;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end

        DATA: begin
          if (timer_zero_s) begin
            timer_q <= TIMER_RELOAD;
            if (idx_q == 3'd7) begin
`ifdef STROBE_UART_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              sh_q    <= {1'b0, sh_q[7:1]};
              tx_q    <= sh_q[1];
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end

`ifdef STROBE_UART_PARITY_EN
        PARITY: begin
          if (timer_zero_s) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            timer_q <= TIMER_RELOAD;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
`endif

        STOP: begin
          if (timer_zero_s) begin
            if (pop_s) begin
              // Next byte already waiting: start bit follows immediately.
              state_q <= START;
              sh_q    <= rd_data_s;
`ifdef STROBE_UART_PARITY_EN
              par_q   <= even_parity(rd_data_s);
`endif
              tx_q    <= 1'b0;
              busy_q  <= 1'b1;
              timer_q <= TIMER_RELOAD;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          timer_q <= 16'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers
  // ---------------------------------------------------------------------------
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;

endmodule
